// File: rtl/vmix_mem_pkg.sv
// Shared definitions for the video_mix memory-side engines: MCB opcodes,
// line-fetch state encoding and default bus geometry.
package vmix_mem_pkg;

   localparam int unsigned DWIDTH_DEF  = 128;
   localparam int unsigned COL_W_DEF   = 13;
   localparam int unsigned LINE_W_DEF  = 11;
   localparam int unsigned MCB_ADDR_W  = 30;

   localparam logic [2:0] MCB_READ  = 3'b001;
   localparam logic [2:0] MCB_WRITE = 3'b000;

   typedef enum logic [2:0] {
      FS_IDLE,
      FS_ISSUE,
      FS_WAIT_DATA,
      FS_DATA,
      FS_NEXT,
      FS_DONE
   } fetch_state_e;

   // MCB command opcode for a read or write request
   function automatic logic [2:0] mcb_instr(input logic is_write);
      return is_write ? MCB_WRITE : MCB_READ;
   endfunction

endpackage

// File: rtl/fetch_addr_gen.sv
// Byte address builder for one fetch burst: frame bit, line field and the
// per-channel column offset advanced by whole bursts.
module fetch_addr_gen
   import vmix_mem_pkg::*;
#(
   parameter int unsigned DWIDTH      = DWIDTH_DEF,
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned COL_W       = COL_W_DEF,
   parameter int unsigned LINE_W      = LINE_W_DEF,
   parameter int unsigned FRAME_SHIFT = 24
) (
   input  logic                     frame,
   input  logic [LINE_W-1:0]        line,
   input  logic [1:0]               ch_idx,
   input  logic [3:0]               brst_idx,
   input  logic [5:0]               cfg_bl,
   input  logic [NUM_CH*COL_W-1:0]  col_off,
   output logic [MCB_ADDR_W-1:0]    byte_addr
);

   localparam int unsigned BYTES_PER_WORD = DWIDTH / 8;

   logic [COL_W-1:0] col_sel;
   logic [COL_W-1:0] brst_off;
   logic [COL_W-1:0] col;

   always_comb begin
      col_sel = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (ch_idx == 2'(i)) col_sel = col_off[i*COL_W +: COL_W];
      end
   end

   // Column arithmetic wraps modulo the column field width
   assign brst_off = COL_W'(brst_idx) * (COL_W'(cfg_bl) + COL_W'(1)) * COL_W'(BYTES_PER_WORD);
   assign col      = col_sel + brst_off;

   always_comb begin
      byte_addr                  = '0;
      byte_addr[FRAME_SHIFT]     = frame;
      byte_addr[COL_W +: LINE_W] = line;
      byte_addr[COL_W-1:0]       = col;
   end

endmodule

// File: rtl/rd_line_fetch.sv
// Line-fetch engine: reads one display line per request from MCB frame memory
// as NUM_CH segments of bursts and streams the words with channel tags.
module rd_line_fetch
   import vmix_mem_pkg::*;
#(
   parameter int unsigned DWIDTH      = DWIDTH_DEF,
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned COL_W       = COL_W_DEF,
   parameter int unsigned LINE_W      = LINE_W_DEF,
   parameter int unsigned FRAME_SHIFT = 24,
   parameter int unsigned RD_THRESH   = 8
) (
   input  logic                     memclk,
   input  logic                     mem_rst_n,
   input  logic [5:0]               cfg_bl,
   input  logic [3:0]               cfg_brst_per_ch,
   input  logic [NUM_CH*COL_W-1:0]  cfg_col_off,
   input  logic [LINE_W-1:0]        cfg_lines,
   input  logic                     frame_sel,
   input  logic                     frame_start,
   input  logic                     line_req,
   output logic                     busy,
   output logic                     line_done,
   input  logic                     arb_grant,
   output logic                     mcb_cmd_en,
   output logic [2:0]               mcb_cmd_instr,
   output logic [5:0]               mcb_cmd_bl,
   output logic [29:0]              mcb_cmd_byte_addr,
   input  logic                     mcb_cmd_full,
   output logic                     mcb_rd_en,
   input  logic [DWIDTH-1:0]        mcb_rd_data,
   input  logic                     mcb_rd_empty,
   input  logic [6:0]               mcb_rd_count,
   output logic [DWIDTH-1:0]        out_data,
   output logic [1:0]               out_ch,
   output logic                     out_last,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

   fetch_state_e        state, state_n;
   logic                frame_q;
   logic [LINE_W-1:0]   line_cnt;
   logic                fs_pend;
   logic [1:0]          ch_idx;
   logic [3:0]          brst_idx;
   logic [5:0]          word_cnt;
   logic [29:0]         addr_c;
   logic [3:0]          brst_last;
   logic [6:0]          burst_words;
   logic [6:0]          rd_thresh;
   logic                last_brst, last_ch, last_word;
   logic                issue_go, rd_go;

   fetch_addr_gen #(
      .DWIDTH      (DWIDTH),
      .NUM_CH      (NUM_CH),
      .COL_W       (COL_W),
      .LINE_W      (LINE_W),
      .FRAME_SHIFT (FRAME_SHIFT)
   ) u_addr_gen (
      .frame     (frame_q),
      .line      (line_cnt),
      .ch_idx    (ch_idx),
      .brst_idx  (brst_idx),
      .cfg_bl    (cfg_bl),
      .col_off   (cfg_col_off),
      .byte_addr (addr_c)
   );

   // A burst count of zero behaves as a single burst per channel
   assign brst_last   = (cfg_brst_per_ch == 4'd0) ? 4'd0 : cfg_brst_per_ch - 4'd1;
   assign last_brst   = (brst_idx == brst_last);
   assign last_ch     = (ch_idx == LAST_CH);
   assign last_word   = (word_cnt == cfg_bl);
   assign burst_words = {1'b0, cfg_bl} + 7'd1;
   assign rd_thresh   = (burst_words < 7'(RD_THRESH)) ? burst_words : 7'(RD_THRESH);

   assign issue_go = (state == FS_ISSUE) && arb_grant && !mcb_cmd_full;
   // Zero-latency drain; out_valid doubles as the downstream write strobe
   assign rd_go    = (state == FS_DATA) && !mcb_rd_empty && out_ready;

   assign mcb_rd_en     = rd_go;
   assign out_valid     = rd_go;
   assign out_data      = mcb_rd_data;
   assign out_ch        = ch_idx;
   assign out_last      = rd_go && last_word && last_brst && last_ch;
   assign mcb_cmd_instr = mcb_instr(1'b0);
   assign mcb_cmd_bl    = cfg_bl;

   always_ff @(posedge memclk) begin
      if (!mem_rst_n) state <= FS_IDLE;
      else            state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         FS_IDLE:      if (line_req) state_n = FS_ISSUE;
         FS_ISSUE:     if (issue_go) state_n = FS_WAIT_DATA;
         FS_WAIT_DATA: if (!mcb_rd_empty && (mcb_rd_count >= rd_thresh)) state_n = FS_DATA;
         FS_DATA:      if (rd_go && last_word) state_n = FS_NEXT;
         FS_NEXT:      state_n = (last_brst && last_ch) ? FS_DONE : FS_ISSUE;
         FS_DONE:      state_n = FS_IDLE;
         default:      state_n = FS_IDLE;
      endcase
   end

   always_ff @(posedge memclk) begin
      if (!mem_rst_n) begin
         busy              <= 1'b0;
         line_done         <= 1'b0;
         mcb_cmd_en        <= 1'b0;
         mcb_cmd_byte_addr <= '0;
         frame_q           <= 1'b0;
         ch_idx            <= '0;
         brst_idx          <= '0;
         word_cnt          <= '0;
      end else begin
         busy       <= (state_n != FS_IDLE);
         line_done  <= (state_n == FS_DONE);
         mcb_cmd_en <= issue_go;
         if (issue_go) mcb_cmd_byte_addr <= addr_c;
         case (state)
            FS_IDLE: begin
               if (line_req) begin
                  frame_q  <= frame_sel;
                  ch_idx   <= '0;
                  brst_idx <= '0;
                  word_cnt <= '0;
               end
            end
            FS_DATA: begin
               if (rd_go) word_cnt <= last_word ? 6'd0 : word_cnt + 6'd1;
            end
            FS_NEXT: begin
               if (!last_brst) begin
                  brst_idx <= brst_idx + 4'd1;
               end else if (!last_ch) begin
                  ch_idx   <= ch_idx + 2'd1;
                  brst_idx <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Line counter; a frame_start seen mid-line is deferred to line completion
   always_ff @(posedge memclk) begin
      if (!mem_rst_n) begin
         line_cnt <= '0;
         fs_pend  <= 1'b0;
      end else if (state == FS_DONE) begin
         fs_pend <= 1'b0;
         if (fs_pend || frame_start)     line_cnt <= '0;
         else if (line_cnt == cfg_lines) line_cnt <= '0;
         else                            line_cnt <= line_cnt + LINE_W'(1);
      end else if (frame_start) begin
         if (state == FS_IDLE) line_cnt <= '0;
         else                  fs_pend  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rd_line_fetch.sv
// Scoreboard bench for rd_line_fetch with a behavioural MCB read port model.
module tb_rd_line_fetch;

   localparam int NUM_CH = 2;
   localparam int DW     = 128;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [1:0]    ch;
      logic          last;
   } exp_word_t;

   logic            memclk = 1'b0;
   logic            mem_rst_n;
   logic [5:0]      cfg_bl;
   logic [3:0]      cfg_brst_per_ch;
   logic [25:0]     cfg_col_off;
   logic [10:0]     cfg_lines;
   logic            frame_sel, frame_start, line_req;
   logic            busy, line_done, arb_grant;
   logic            mcb_cmd_en, mcb_cmd_full, mcb_rd_en, mcb_rd_empty;
   logic [2:0]      mcb_cmd_instr;
   logic [5:0]      mcb_cmd_bl;
   logic [29:0]     mcb_cmd_byte_addr;
   logic [DW-1:0]   mcb_rd_data, out_data;
   logic [6:0]      mcb_rd_count;
   logic [1:0]      out_ch;
   logic            out_last, out_valid, out_ready;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0, words_seen = 0, cmd_cnt = 0, exp_total = 0;
   int m_line = 0;
   exp_word_t   exp_w[$];
   logic [29:0] exp_a[$];
   logic [29:0] cmd_log[$];
   logic [DW-1:0] rfifo[$];
   logic [29:0] mcmd_q[$];
   logic [29:0] fill_addr;
   int fill_left = 0, fill_dly = 0, fill_w = 0;

   always #5 memclk = ~memclk;

   rd_line_fetch dut (
      .memclk(memclk), .mem_rst_n(mem_rst_n), .cfg_bl(cfg_bl),
      .cfg_brst_per_ch(cfg_brst_per_ch), .cfg_col_off(cfg_col_off),
      .cfg_lines(cfg_lines), .frame_sel(frame_sel), .frame_start(frame_start),
      .line_req(line_req), .busy(busy), .line_done(line_done),
      .arb_grant(arb_grant), .mcb_cmd_en(mcb_cmd_en), .mcb_cmd_instr(mcb_cmd_instr),
      .mcb_cmd_bl(mcb_cmd_bl), .mcb_cmd_byte_addr(mcb_cmd_byte_addr),
      .mcb_cmd_full(mcb_cmd_full), .mcb_rd_en(mcb_rd_en), .mcb_rd_data(mcb_rd_data),
      .mcb_rd_empty(mcb_rd_empty), .mcb_rd_count(mcb_rd_count), .out_data(out_data),
      .out_ch(out_ch), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
   );

   function automatic logic [DW-1:0] mk_word(input logic [29:0] a, input int w);
      return {82'd0, a, 16'(w)};
   endfunction

   function automatic logic [29:0] exp_addr(input int c, input int b);
      logic [12:0] col;
      col = 13'(int'(cfg_col_off[c*13 +: 13]) + b * (int'(cfg_bl) + 1) * 16);
      return (30'(frame_sel) << 24) | (30'(m_line) << 13) | 30'(col);
   endfunction

   // MCB read port: 3-cycle command latency, then one word per cycle
   always @(posedge memclk) begin : mcb_model
      logic        rd_now, cmd_now, rst_now;
      logic [29:0] a_now;
      rd_now  = mcb_rd_en;
      cmd_now = mcb_cmd_en;
      rst_now = mem_rst_n;
      a_now   = mcb_cmd_byte_addr;
      #1;
      if (!rst_now) begin
         rfifo.delete();
         mcmd_q.delete();
         fill_left = 0;
         fill_dly  = 0;
      end else begin
         if (rd_now && rfifo.size() > 0) void'(rfifo.pop_front());
         if (cmd_now) mcmd_q.push_back(a_now);
         if (fill_left == 0 && mcmd_q.size() > 0) begin
            fill_addr = mcmd_q.pop_front();
            fill_left = int'(cfg_bl) + 1;
            fill_w    = 0;
            fill_dly  = 3;
         end else if (fill_dly > 0) begin
            fill_dly--;
         end else if (fill_left > 0) begin
            rfifo.push_back(mk_word(fill_addr, fill_w));
            fill_w++;
            fill_left--;
         end
      end
      mcb_rd_empty = (rfifo.size() == 0);
      mcb_rd_count = (rfifo.size() > 127) ? 7'd127 : 7'(rfifo.size());
      mcb_rd_data  = (rfifo.size() > 0) ? rfifo[0] : '0;
   end

   // Scoreboard: output words and command addresses
   always @(negedge memclk) begin : monitor
      exp_word_t e;
      logic [29:0] ea;
      if (out_valid) begin
         words_seen++;
         n_tests++;
         if (exp_w.size() == 0) begin
            n_fail++;
            $display("FAIL word_unexpected: got data=%h ch=%0d, need no word", out_data, out_ch);
         end else begin
            e = exp_w.pop_front();
            if (out_data !== e.data || out_ch !== e.ch || out_last !== e.last) begin
               n_fail++;
               $display("FAIL word: got data=%h ch=%0d last=%0b, need data=%h ch=%0d last=%0b",
                        out_data, out_ch, out_last, e.data, e.ch, e.last);
            end
         end
      end
      if (mcb_cmd_en) begin
         cmd_cnt++;
         cmd_log.push_back(mcb_cmd_byte_addr);
         n_tests++;
         if (exp_a.size() == 0) begin
            n_fail++;
            $display("FAIL cmd_unexpected: got addr=%h, need no command", mcb_cmd_byte_addr);
         end else begin
            ea = exp_a.pop_front();
            if (mcb_cmd_byte_addr !== ea || mcb_cmd_instr !== 3'b001 || mcb_cmd_bl !== cfg_bl) begin
               n_fail++;
               $display("FAIL cmd: got addr=%h instr=%b bl=%0d, need addr=%h instr=001 bl=%0d",
                        mcb_cmd_byte_addr, mcb_cmd_instr, mcb_cmd_bl, ea, cfg_bl);
            end
         end
      end
      if (line_done) done_cnt++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic push_line();
      int bpc;
      exp_word_t e;
      logic [29:0] a;
      bpc = (cfg_brst_per_ch == 4'd0) ? 1 : int'(cfg_brst_per_ch);
      for (int c = 0; c < NUM_CH; c++) begin
         for (int b = 0; b < bpc; b++) begin
            a = exp_addr(c, b);
            exp_a.push_back(a);
            for (int w = 0; w <= int'(cfg_bl); w++) begin
               e.data = mk_word(a, w);
               e.ch   = 2'(c);
               e.last = (c == NUM_CH - 1) && (b == bpc - 1) && (w == int'(cfg_bl));
               exp_w.push_back(e);
            end
         end
      end
      exp_total = NUM_CH * bpc * (int'(cfg_bl) + 1);
   endtask

   // One complete line; optional out_ready stall, mid-line frame_start, issue blocking
   task automatic run_line(input int stall_at, input int fs_at, input int blk, input bit fs_req);
      int d0, w0, c0;
      bit got, stalled, fs_done;
      if (fs_req) m_line = 0;
      push_line();
      d0 = done_cnt; w0 = words_seen; c0 = cmd_cnt;
      got = 0; stalled = 0; fs_done = 0;
      if (blk == 1) arb_grant = 1'b0;
      else if (blk == 2) mcb_cmd_full = 1'b1;
      @(posedge memclk); #1;
      line_req = 1'b1; frame_start = fs_req;
      @(posedge memclk); #1;
      line_req = 1'b0; frame_start = 1'b0;
      if (blk != 0) begin
         repeat (19) @(posedge memclk);
         #1;
         n_tests++;
         if (cmd_cnt != c0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_blocked: got cmds=%0d busy=%0b, need cmds=0 busy=1", cmd_cnt - c0, busy);
         end
         arb_grant = 1'b1; mcb_cmd_full = 1'b0;
         repeat (5) @(posedge memclk);
         #1;
         n_tests++;
         if (cmd_cnt - c0 != 1) begin
            n_fail++;
            $display("FAIL issue_release: got cmds=%0d, need 1", cmd_cnt - c0);
         end
      end
      for (int cyc = 0; cyc < 6000 && !got; cyc++) begin
         @(posedge memclk); #1;
         if (stall_at > 0 && !stalled && words_seen - w0 >= stall_at) begin
            out_ready = 1'b0; stalled = 1;
            for (int k = 0; k < 10; k++) begin
               @(negedge memclk);
               n_tests++;
               if (mcb_rd_en !== 1'b0 || out_valid !== 1'b0) begin
                  n_fail++;
                  $display("FAIL stall: got rd_en=%0b out_valid=%0b, need 0 0", mcb_rd_en, out_valid);
               end
               @(posedge memclk); #1;
            end
            out_ready = 1'b1;
         end
         if (fs_at > 0 && !fs_done && words_seen - w0 >= fs_at) begin
            frame_start = 1'b1;
            @(posedge memclk); #1;
            frame_start = 1'b0; fs_done = 1;
         end
         if (done_cnt != d0) got = 1;
      end
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL line_timeout: got no line_done, need one within 6000 cycles");
      end
      repeat (3) @(posedge memclk);
      #1;
      n_tests++;
      if (done_cnt - d0 != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL line_done_count: got %0d busy=%0b, need 1 busy=0", done_cnt - d0, busy);
      end
      n_tests++;
      if (words_seen - w0 != exp_total || exp_w.size() != 0 || exp_a.size() != 0) begin
         n_fail++;
         $display("FAIL word_total: got %0d words (%0d words %0d cmds left), need %0d",
                  words_seen - w0, exp_w.size(), exp_a.size(), exp_total);
      end
      exp_w.delete(); exp_a.delete();
      if (fs_at > 0) m_line = 0;
      else m_line = (m_line == int'(cfg_lines)) ? 0 : m_line + 1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge memclk);
      #1;
      n_tests++;
      if ({busy, line_done, mcb_cmd_en, mcb_rd_en, out_valid, out_last, out_ch} !== 8'b0 ||
          mcb_cmd_byte_addr !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_state: got busy=%0b done=%0b cmd_en=%0b rd_en=%0b valid=%0b last=%0b ch=%0d addr=%h, need all 0",
                  busy, line_done, mcb_cmd_en, mcb_rd_en, out_valid, out_last, out_ch, mcb_cmd_byte_addr);
      end
      mem_rst_n = 1'b1;
      repeat (2) @(posedge memclk);
      #1;
      n_tests++;
      if (busy !== 1'b0 || mcb_cmd_en !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%0b cmd_en=%0b, need 0 0", busy, mcb_cmd_en);
      end
   endtask

   task automatic test_basic();
      logic [29:0] want[4];
      want[0] = 30'h0A000; want[1] = 30'h0A3C0; want[2] = 30'h0A3C0; want[3] = 30'h0A780;
      cfg_bl = 6'd3; cfg_brst_per_ch = 4'd1;
      run_line(0, 0, 0, 1'b1);
      for (int i = 1; i < 5; i++) run_line(0, 0, 0, 1'b0);
      cfg_bl = 6'd59; cfg_brst_per_ch = 4'd2;
      cmd_log.delete();
      run_line(0, 0, 0, 1'b0);
      n_tests++;
      if (cmd_log.size() != 4) begin
         n_fail++;
         $display("FAIL basic_cmd_count: got %0d, need 4", cmd_log.size());
      end
      for (int i = 0; i < 4 && i < cmd_log.size(); i++) begin
         n_tests++;
         if (cmd_log[i] !== want[i]) begin
            n_fail++;
            $display("FAIL basic_addr%0d: got %h, need %h", i, cmd_log[i], want[i]);
         end
      end
   endtask

   task automatic test_brst_zero();
      cfg_bl = 6'd3; cfg_brst_per_ch = 4'd0; frame_sel = 1'b1;
      cmd_log.delete();
      run_line(0, 0, 0, 1'b0);
      n_tests++;
      if (cmd_log.size() != 2) begin
         n_fail++;
         $display("FAIL brst_zero_cmds: got %0d, need 2", cmd_log.size());
      end
      frame_sel = 1'b0;
   endtask

   task automatic test_stall();
      cfg_bl = 6'd59; cfg_brst_per_ch = 4'd2;
      run_line(30, 0, 0, 1'b0);
   endtask

   task automatic test_issue_block();
      cfg_bl = 6'd3; cfg_brst_per_ch = 4'd1;
      run_line(0, 0, 1, 1'b0);
      run_line(0, 0, 2, 1'b0);
   endtask

   task automatic test_frame_start_mid();
      logic [29:0] a;
      cfg_bl = 6'd15; cfg_brst_per_ch = 4'd2;
      run_line(0, 10, 0, 1'b0);
      cmd_log.delete();
      run_line(0, 0, 0, 1'b0);
      a = (cmd_log.size() > 0) ? cmd_log[0] : 30'h3FFFFFFF;
      n_tests++;
      if (a[23:13] !== 11'd0) begin
         n_fail++;
         $display("FAIL fs_mid_next_line: got line %0d, need 0", a[23:13]);
      end
   endtask

   task automatic test_wrap();
      logic [29:0] a;
      cfg_bl = 6'd0; cfg_brst_per_ch = 4'd1;
      for (int i = 0; i <= 900; i++) begin
         frame_sel = 1'(i % 2);
         cmd_log.delete();
         run_line(0, 0, 0, i == 0);
         a = (cmd_log.size() > 0) ? cmd_log[0] : 30'h3FFFFFFF;
         if (i == 899) begin
            n_tests++;
            if (a[23:13] !== 11'd899 || a[24] !== 1'b1) begin
               n_fail++;
               $display("FAIL wrap_line899: got line %0d frame %0b, need 899 1", a[23:13], a[24]);
            end
         end
         if (i == 900) begin
            n_tests++;
            if (a[23:13] !== 11'd0) begin
               n_fail++;
               $display("FAIL wrap_to_zero: got line %0d, need 0", a[23:13]);
            end
         end
      end
      frame_sel = 1'b0;
   endtask

   task automatic test_reset_mid();
      int d0, w0;
      logic [29:0] a;
      cfg_bl = 6'd59; cfg_brst_per_ch = 4'd2;
      push_line();
      d0 = done_cnt; w0 = words_seen;
      @(posedge memclk); #1; line_req = 1'b1;
      @(posedge memclk); #1; line_req = 1'b0;
      for (int cyc = 0; cyc < 2000 && words_seen - w0 < 50; cyc++) begin
         @(posedge memclk); #1;
      end
      mem_rst_n = 1'b0;
      @(posedge memclk); #1;
      mem_rst_n = 1'b1;
      n_tests++;
      if ({busy, line_done, mcb_cmd_en, mcb_rd_en, out_valid, out_last, out_ch} !== 8'b0 ||
          mcb_cmd_byte_addr !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got busy=%0b done=%0b cmd_en=%0b rd_en=%0b valid=%0b last=%0b ch=%0d addr=%h, need all 0",
                  busy, line_done, mcb_cmd_en, mcb_rd_en, out_valid, out_last, out_ch, mcb_cmd_byte_addr);
      end
      exp_w.delete(); exp_a.delete();
      repeat (10) @(posedge memclk);
      #1;
      n_tests++;
      if (done_cnt != d0) begin
         n_fail++;
         $display("FAIL reset_no_done: got %0d line_done, need 0", done_cnt - d0);
      end
      m_line = 0;
      cmd_log.delete();
      run_line(0, 0, 0, 1'b0);
      a = (cmd_log.size() > 0) ? cmd_log[0] : 30'h3FFFFFFF;
      n_tests++;
      if (a !== 30'h0) begin
         n_fail++;
         $display("FAIL reset_restart_addr: got %h, need 0", a);
      end
   endtask

   initial begin
      mem_rst_n = 1'b0; line_req = 1'b0; frame_start = 1'b0; frame_sel = 1'b0;
      arb_grant = 1'b1; mcb_cmd_full = 1'b0; out_ready = 1'b1;
      cfg_bl = 6'd3; cfg_brst_per_ch = 4'd1; cfg_lines = 11'd899;
      cfg_col_off = {13'd960, 13'd0};
      mcb_rd_empty = 1'b1; mcb_rd_count = 7'd0; mcb_rd_data = '0;
      test_reset();
      test_basic();
      test_brst_zero();
      test_stall();
      test_issue_block();
      test_frame_start_mid();
      test_reset_mid();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
